// File: rtl/arith_responder_if.sv
// arith_responder_if
//   Request and response channels of the add/subtract responder, bundled as one
//   interface.
//   slave  : the responder side. It takes the request fields and the response
//            ready, and drives the request ready, the response fields and the
//            occupancy count.
//   master : the initiator and consumer side, which is the mirror image.
//   Signals:
//     i_req_valid / o_req_ready  request handshake
//     i_req_op, i_req_id         op select (0 = add, 1 = subtract) and tag
//     i_a, i_b                   32-bit signed operands
//     o_rsp_valid / i_rsp_ready  response handshake
//     o_rsp_op, o_rsp_id         op and tag of the head entry
//     o_rsp_data                 result of the head entry
//     o_count                    FIFO occupancy, 0..DEPTH
interface arith_responder_if #(
    parameter int DEPTH = 4,
    parameter int ID_W  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              i_req_valid;
    logic              o_req_ready;
    logic              i_req_op;
    logic [ID_W-1:0]   i_req_id;
    logic [31:0]       i_a;
    logic [31:0]       i_b;

    logic              o_rsp_valid;
    logic              i_rsp_ready;
    logic              o_rsp_op;
    logic [ID_W-1:0]   o_rsp_id;
    logic [31:0]       o_rsp_data;
    logic [CNT_W-1:0]  o_count;

    modport slave (
        input  i_req_valid, i_req_op, i_req_id, i_a, i_b, i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_op, o_rsp_id, o_rsp_data, o_count
    );

    modport master (
        output i_req_valid, i_req_op, i_req_id, i_a, i_b, i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_op, o_rsp_id, o_rsp_data, o_count
    );
endinterface

// File: rtl/arith_responder.sv
// arith_responder
//   Accepts add/subtract requests, computes the 32-bit modulo-2^32 result when
//   a request is accepted, and queues the result with its op and tag in an
//   in-order FIFO of DEPTH entries. Responses come from registered storage at
//   the FIFO head. Nothing bypasses the storage, so a response appears no
//   earlier than one cycle after its request is accepted.
//   Ports:
//     i_clk  rising-edge clock
//     i_rst  synchronous active-high reset. It clears the pointers, the count
//            and every storage entry.
//     bus    arith_responder_if.slave (request and response channels, count)
//   Parameters:
//     DEPTH  FIFO entries; must be a power of two and at least 2
//     ID_W   tag width
module arith_responder #(
    parameter int DEPTH = 4,
    parameter int ID_W  = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    arith_responder_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic [31:0]      mem_data [DEPTH];
    logic [ID_W-1:0]  mem_id   [DEPTH];
    logic             mem_op   [DEPTH];

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [31:0]      result;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Ready depends only on the current occupancy. A full FIFO refuses a push
    // even when a pop happens in the same cycle.
    assign bus.o_req_ready = !full && !i_rst;
    assign bus.o_rsp_valid = !empty;

    assign push = bus.i_req_valid && bus.o_req_ready;
    assign pop  = bus.o_rsp_valid && bus.i_rsp_ready;

    // Plain modulo-2^32 arithmetic. There is no saturation and no overflow flag.
    assign result = bus.i_req_op ? (bus.i_a - bus.i_b) : (bus.i_a + bus.i_b);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_id[i]   <= '0;
                mem_op[i]   <= 1'b0;
            end
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= result;
                mem_id[wr_ptr]   <= bus.i_req_id;
                mem_op[wr_ptr]   <= bus.i_req_op;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign bus.o_rsp_data = mem_data[rd_ptr];
    assign bus.o_rsp_id   = mem_id[rd_ptr];
    assign bus.o_rsp_op   = mem_op[rd_ptr];
    assign bus.o_count    = count;
endmodule

// File: doc/arith_responder.md
# arith_responder

Sequential responder for add/subtract requests. Initiator modules issue operand pairs with a 1-bit op select and a tag over a valid/ready request channel. This block computes the 32-bit two's-complement sum or difference, buffers results in an in-order FIFO and returns them over a valid/ready response channel. It sits between one or more request-issuing modules (muxed upstream) and the shared arithmetic service.

## Interface
Parameters:
- DEPTH, 4, response FIFO entries; power of two, ≥2
- ID_W, 4, request/response tag width

Ports:
- i_clk  input  1  clock; all state updates on rising edge
- i_rst  input  1  reset; synchronous, active-high
- i_req_valid  input  1  request present
- o_req_ready  output  1  block can accept request this cycle
- i_req_op  input  1  0 = add (i_a + i_b), 1 = subtract (i_a − i_b)
- i_req_id  input  ID_W  tag, echoed on response
- i_a  input  32  operand A, signed int
- i_b  input  32  operand B, signed int
- o_rsp_valid  output  1  response at FIFO head
- i_rsp_ready  input  1  consumer takes response this cycle
- o_rsp_op  output  1  op of head entry
- o_rsp_id  output  ID_W  tag of head entry
- o_rsp_data  output  32  result of head entry
- o_count  output  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Push: i_req_valid && o_req_ready at a rising edge. Result computed combinationally from i_a/i_b/i_req_op and written with op and id into mem[wr_ptr]. wr_ptr increments.
- Pop: o_rsp_valid && i_rsp_ready at a rising edge. rd_ptr increments.
- Arithmetic is 32-bit modulo 2^32 with no saturation and no overflow flag. 0x7FFFFFFF + 1 = 0x80000000. 0x80000000 − 1 = 0x7FFFFFFF.
- o_req_ready = !full && !i_rst. There is no combinational dependence on i_rsp_ready: a full FIFO refuses a push even when a pop occurs in the same cycle.
- o_rsp_valid = !empty. o_rsp_op/id/data = mem[rd_ptr], registered storage, no bypass.
- Responses leave strictly in acceptance order.
- Simultaneous push and pop (count between 1 and DEPTH−1): both occur and count is unchanged.
- Pop and push at count 0: no pop is possible (o_rsp_valid is low), so only the push occurs.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are derived from o_count (0 = empty, DEPTH = full).
- The consumer must hold nothing stable. The block keeps o_rsp_* stable while o_rsp_valid && !i_rsp_ready.
- The initiator must hold i_req_* stable while i_req_valid && !o_req_ready. The block does not depend on this for correctness.
- Reset:
  - Pointers and count go to 0. All mem entries are cleared to 0.
  - After the reset edge: o_rsp_valid = 0, o_rsp_op/id/data = 0, o_count = 0.
  - o_req_ready = 0 while i_rst is high, and 1 in the first cycle after i_rst falls.
- Reset mid-operation discards all buffered responses. A request presented in the same cycle as i_rst is not accepted.

## Timing
- Latency is one cycle when the FIFO is empty and the consumer is ready. A request accepted at edge N has o_rsp_valid high after edge N and is popped at edge N+1.
- Throughput is one request per cycle while count < DEPTH.
- With i_rsp_ready held high, occupancy stays at 1 in steady state.
- When the FIFO is full, o_req_ready falls after the push edge that fills it. It rises after the first pop edge.
- o_count updates on the same edge as the push or pop.

## Test plan
- Single add: i_a=5, i_b=7, op=0, id=3 → the cycle after acceptance shows o_rsp_valid=1, data=12, id=3, op=0, count=1. Pop → count=0, valid=0.
- Subtract and wrap:
  - a=3, b=10, op=1 → data=0xFFFFFFF9 (−7).
  - a=0x7FFFFFFF, b=1, op=0 → 0x80000000.
  - a=0x80000000, b=1, op=1 → 0x7FFFFFFF.
- Backpressure fill (DEPTH=4): i_rsp_ready=0, issue ids 0..5 back-to-back → ids 0–3 accepted, o_req_ready=0 and count=4 after the 4th push. Raise i_rsp_ready → responses come out in order 0,1,2,3, then ids 4 and 5 are accepted.
- Simultaneous push/pop: hold count=2 with valid and ready high on both channels for 10 cycles → count stays 2, and results are returned in order with 2-cycle latency.
- Full plus pop: at count=4, assert i_req_valid and i_rsp_ready in the same cycle → only the pop occurs (count=3). The request is accepted in the next cycle.
- Reset mid-operation: count=3, assert i_rst for 1 cycle alongside i_req_valid=1 → next cycle count=0, o_rsp_valid=0, o_rsp_data=0, and the request is not accepted. o_req_ready is 0 during reset and 1 afterward.
